// File: rtl/reg_window_ctrl_if.sv
// rtl/reg_window_ctrl_if.sv - CPU, register-file and memory port bundle for the window manager
interface reg_window_ctrl_if #(
    parameter int DW = 16,
    parameter int AW = 8
);
    // Control unit side
    logic          Call;
    logic          Return;
    logic [1:0]    WndSel;
    logic          Busy;
    logic          Err;

    // Register file spill/fill port
    logic [2:0]    Rf_Addr;
    logic          Rf_We;
    logic [DW-1:0] Rf_WData;
    logic [DW-1:0] Rf_RData;

    // Data memory stack port
    logic          Mem_Req;
    logic          Mem_We;
    logic [AW-1:0] Mem_Addr;
    logic [DW-1:0] Mem_WData;
    logic [DW-1:0] Mem_RData;
    logic          Mem_Ack;

    // Environment view: drives requests and returns register/memory data
    modport master (
        output Call, Return, Rf_RData, Mem_RData, Mem_Ack,
        input  WndSel, Busy, Err, Rf_Addr, Rf_We, Rf_WData,
        input  Mem_Req, Mem_We, Mem_Addr, Mem_WData
    );

    // Window manager view
    modport slave (
        input  Call, Return, Rf_RData, Mem_RData, Mem_Ack,
        output WndSel, Busy, Err, Rf_Addr, Rf_We, Rf_WData,
        output Mem_Req, Mem_We, Mem_Addr, Mem_WData
    );
endinterface

// File: rtl/reg_window_ctrl.sv
// rtl/reg_window_ctrl.sv - window pointer manager with spill/fill of private register pairs
module reg_window_ctrl #(
    parameter int DW    = 16,
    parameter int AW    = 8,
    parameter int DEPTH = 16
) (
    input  logic              Clock,
    input  logic              Rst,
    reg_window_ctrl_if.slave  bus
);

    localparam int SCW = $clog2(DEPTH + 1);
    localparam logic [SCW-1:0] DEPTH_C = SCW'(DEPTH);
    localparam logic [1:0]     RES_MAX = 2'd3;
    localparam logic [1:0]     RES_MIN = 2'd1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SPILL0 = 3'd1,
        SPILL1 = 3'd2,
        FILL0  = 3'd3,
        FILL1  = 3'd4
    } state_t;

    state_t         state, state_nxt;
    logic [1:0]     cwp, cwp_nxt;
    logic [1:0]     res_cnt, res_nxt;
    logic [SCW-1:0] spill_cnt, spill_nxt;
    logic           err_q, err_nxt;

    logic [1:0]     old_wnd;
    logic [1:0]     new_wnd;
    logic [SCW-1:0] spill_dec;
    logic           k;

    logic [2:0]     rf_addr;
    logic           rf_we;
    logic [DW-1:0]  rf_wdata;
    logic           mem_req;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;

    // Oldest resident window is evicted on overflow; the window below CWP is restored on underflow.
    // CWP does not move until the second transfer completes, so both stay fixed during a transfer.
    assign old_wnd   = cwp - 2'd2;
    assign new_wnd   = cwp - 2'd1;
    assign spill_dec = spill_cnt - SCW'(1);

    // State, window pointer, occupancy counters and the registered error pulse
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            cwp       <= 2'd0;
            res_cnt   <= RES_MIN;
            spill_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cwp       <= cwp_nxt;
            res_cnt   <= res_nxt;
            spill_cnt <= spill_nxt;
            err_q     <= err_nxt;
        end
    end

    // Next-state decode and the register-file / memory port drive for each transfer step
    always_comb begin
        state_nxt = state;
        cwp_nxt   = cwp;
        res_nxt   = res_cnt;
        spill_nxt = spill_cnt;
        err_nxt   = 1'b0;
        k         = (state == SPILL1) || (state == FILL1);
        rf_addr   = '0;
        rf_we     = 1'b0;
        rf_wdata  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state)
            IDLE: begin
                if (bus.Call && bus.Return) begin
                    err_nxt = 1'b1;
                end else if (bus.Call) begin
                    if (res_cnt < RES_MAX) begin
                        cwp_nxt = cwp + 2'd1;
                        res_nxt = res_cnt + 2'd1;
                    end else if (spill_cnt < DEPTH_C) begin
                        state_nxt = SPILL0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (bus.Return) begin
                    if (res_cnt > RES_MIN) begin
                        cwp_nxt = cwp - 2'd1;
                        res_nxt = res_cnt - 2'd1;
                    end else if (spill_cnt != '0) begin
                        state_nxt = FILL0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end

            SPILL0, SPILL1: begin
                rf_addr   = {old_wnd, k};
                mem_wdata = bus.Rf_RData;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = AW'({spill_cnt, k});
                if (bus.Mem_Ack) begin
                    if (!k) begin
                        state_nxt = SPILL1;
                    end else begin
                        state_nxt = IDLE;
                        cwp_nxt   = cwp + 2'd1;
                        spill_nxt = spill_cnt + SCW'(1);
                    end
                end
            end

            FILL0, FILL1: begin
                mem_req  = 1'b1;
                mem_we   = 1'b0;
                mem_addr = AW'({spill_dec, k});
                if (bus.Mem_Ack) begin
                    rf_we    = 1'b1;
                    rf_addr  = {new_wnd, k};
                    rf_wdata = bus.Mem_RData;
                    if (!k) begin
                        state_nxt = FILL1;
                    end else begin
                        state_nxt = IDLE;
                        cwp_nxt   = cwp - 2'd1;
                        spill_nxt = spill_dec;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.WndSel    = cwp;
    assign bus.Busy      = (state != IDLE);
    assign bus.Err       = err_q;
    assign bus.Rf_Addr   = rf_addr;
    assign bus.Rf_We     = rf_we;
    assign bus.Rf_WData  = rf_wdata;
    assign bus.Mem_Req   = mem_req;
    assign bus.Mem_We    = mem_we;
    assign bus.Mem_Addr  = mem_addr;
    assign bus.Mem_WData = mem_wdata;

endmodule
